// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: drives the instruction memory PC and holds the
// returned word in a one-entry valid/ready slot. Illegal redirects trap to a sticky fault.
module imem_fetch_ctrl #(
  parameter int N         = 32,
  parameter int MEM_BYTES = 32,
  parameter int RESET_PC  = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_done,
  output logic [N-1:0] pc_out,
  input  logic [N-1:0] inst_code,
  output logic         if_valid,
  input  logic         if_ready,
  output logic [N-1:0] if_inst,
  output logic [N-1:0] if_pc,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic         fault,
  output logic [N-1:0] fault_pc
);

  localparam logic [N-1:0] LAST_PC  = N'(MEM_BYTES - 4);
  localparam logic [N-1:0] START_PC = N'(RESET_PC);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t       state;
  logic [N-1:0] next_pc;
  logic         redirect_legal;
  logic         slot_free;

  // The PC only ever holds legal word addresses, so wrapping at the last word is enough.
  assign next_pc        = (pc_out == LAST_PC) ? '0 : pc_out + N'(4);
  assign redirect_legal = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= LAST_PC);
  assign slot_free      = !if_valid || if_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc_out   <= START_PC;
      if_valid <= 1'b0;
      if_inst  <= '0;
      if_pc    <= '0;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_done) state <= RUN;
        end
        RUN: begin
          // A redirect beats everything, including a pending handshake.
          if (redirect_valid) begin
            if_valid <= 1'b0;
            if (redirect_legal) begin
              pc_out <= redirect_pc;
            end else begin
              state    <= FAULT;
              fault    <= 1'b1;
              fault_pc <= redirect_pc;
            end
          end else if (slot_free) begin
            if_inst  <= inst_code;
            if_pc    <= pc_out;
            if_valid <= 1'b1;
            pc_out   <= next_pc;
          end
        end
        FAULT: begin
          if_valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: a driver steps a transaction-level model
// and queues expected fetches; a monitor checks the slot and pops on each handshake.
module tb_imem_fetch_ctrl;

  localparam int N         = 32;
  localparam int MEM_BYTES = 32;
  localparam int RESET_PC  = 0;
  localparam int WORDS     = MEM_BYTES / 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_done = 1'b0;
  logic [N-1:0]  pc_out;
  logic [N-1:0]  inst_code;
  logic          if_valid;
  logic          if_ready = 1'b0;
  logic [N-1:0]  if_inst;
  logic [N-1:0]  if_pc;
  logic          redirect_valid = 1'b0;
  logic [N-1:0]  redirect_pc = '0;
  logic          fault;
  logic [N-1:0]  fault_pc;

  logic [31:0]   mem [WORDS];

  imem_fetch_ctrl #(.N(N), .MEM_BYTES(MEM_BYTES), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .load_done(load_done), .pc_out(pc_out),
    .inst_code(inst_code), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  assign inst_code = mem[pc_out[4:2]];

  int total_checks  = 0;
  int passed_checks = 0;

  // Reference model: 0 = waiting for load, 1 = fetching, 2 = trapped.
  int          m_state;
  logic [31:0] m_fetch;
  bit          m_slot;
  bit          m_fault;
  logic [31:0] m_fault_pc;
  logic [63:0] exp_q[$];

  // Expected DUT outputs for the current cycle, captured before the model advances.
  bit          exp_valid_now;
  logic [31:0] exp_pc_now;
  bit          exp_fault_now;
  logic [31:0] exp_fault_pc_now;
  logic [63:0] exp_item_now;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_checks++;
    if (act === req) passed_checks++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask

  function automatic bit legal_pc(input logic [31:0] a);
    return (a % 4 == 0) && (a <= 32'(MEM_BYTES - 4));
  endfunction

  task automatic snapshot();
    exp_valid_now    = m_slot;
    exp_pc_now       = m_fetch;
    exp_fault_now    = m_fault;
    exp_fault_pc_now = m_fault_pc;
    exp_item_now     = (m_slot && exp_q.size() > 0) ? exp_q[0] : 64'h0;
  endtask

  task automatic model_reset();
    m_state    = 0;
    m_fetch    = RESET_PC;
    m_slot     = 0;
    m_fault    = 0;
    m_fault_pc = 0;
    exp_q.delete();
    snapshot();
  endtask

  task automatic step(input bit ld, input bit rdy, input bit rv, input logic [31:0] rpc);
    @(negedge clk);
    load_done      = ld;
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    snapshot();
    if (m_state == 0) begin
      if (ld) m_state = 1;
    end else if (m_state == 1) begin
      if (rv) begin
        if (m_slot && exp_q.size() > 0) void'(exp_q.pop_back());
        m_slot = 0;
        if (legal_pc(rpc)) m_fetch = rpc;
        else begin
          m_state    = 2;
          m_fault    = 1;
          m_fault_pc = rpc;
        end
      end else if (!m_slot || rdy) begin
        exp_q.push_back({m_fetch, mem[m_fetch / 4]});
        m_slot  = 1;
        m_fetch = (m_fetch + 4) % MEM_BYTES;
      end
    end
  endtask

  task automatic do_reset();
    load_done      = 0;
    if_ready       = 0;
    redirect_valid = 0;
    redirect_pc    = '0;
    reset          = 1;
    #1;
    chk("rst_pc_out", pc_out, RESET_PC);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  // Monitor: checks the current cycle's outputs and retires accepted instructions.
  initial begin
    logic [63:0] item;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        chk("if_valid", {31'b0, if_valid}, {31'b0, exp_valid_now});
        chk("pc_out", pc_out, exp_pc_now);
        chk("fault", {31'b0, fault}, {31'b0, exp_fault_now});
        chk("fault_pc", fault_pc, exp_fault_pc_now);
        if (exp_valid_now) begin
          if (if_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
              chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
              item = exp_q.pop_front();
              chk("accept_if_pc", if_pc, item[63:32]);
              chk("accept_if_inst", if_inst, item[31:0]);
            end
          end else begin
            chk("hold_if_pc", if_pc, exp_item_now[63:32]);
            chk("hold_if_inst", if_inst, exp_item_now[31:0]);
          end
        end
      end
    end
  end

  initial begin
    bit rv;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    model_reset();
    #2;
    do_reset();

    // Load gating, then streaming through the wrap point.
    repeat (5) step(0, 1, 0, 0);
    step(1, 1, 1, 32'h8);
    repeat (12) step(0, 1, 0, 0);

    // Backpressure, then release.
    repeat (3) step(0, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0);

    // Redirect while holding a valid slot.
    step(0, 0, 1, 32'h10);
    repeat (4) step(0, 1, 0, 0);

    // Randomized traffic with legal redirects.
    for (int i = 0; i < 300; i++) begin
      rv = ($urandom_range(0, 15) == 0);
      step($urandom_range(0, 1), rv ? 1'b0 : ($urandom_range(0, 3) != 0), rv,
           32'($urandom_range(0, WORDS - 1) * 4));
    end

    // Misaligned redirect traps; later legal redirect is ignored.
    step(0, 0, 1, 32'h12);
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'h4);
    repeat (4) step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 32'h8);

    // Out-of-range redirect, then asynchronous reset in mid-cycle.
    do_reset();
    step(1, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    step(0, 1, 1, 32'h20);
    repeat (3) step(0, 1, 0, 0);
    do_reset();

    // Upper bits set must also trap.
    step(1, 1, 0, 0);
    repeat (3) step(0, $urandom_range(0, 1), 0, 0);
    step(0, 0, 1, 32'h8000_0004);
    repeat (3) step(0, 1, 1, 32'h0);

    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Fetch sequencer for the byte-addressed instruction memory. It drives the memory's PC input and registers the returned 32-bit instruction into a one-entry output slot with a valid/ready handshake toward decode. It also handles branch/jump redirects and holds off fetching until the memory program load is complete. It traps illegal PCs into a sticky fault state, so the memory is never indexed out of range.

Parameters:
N, 32, PC and instruction width in bits.
MEM_BYTES, 32, instruction memory size in bytes; must be a multiple of 4.
RESET_PC, 0, first fetch address; must be 4-aligned and at most MEM_BYTES-4.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
load_done  input  1  memory program image is loaded; sampled only in IDLE.
pc_out  output  N  address driven to the instruction memory PC input.
inst_code  input  N  combinational read data for pc_out from the instruction memory.
if_valid  output  1  output slot holds an instruction.
if_ready  input  1  decode accepts the slot this cycle.
if_inst  output  N  registered instruction.
if_pc  output  N  PC of if_inst.
redirect_valid  input  1  single-cycle request to change the fetch PC.
redirect_pc  input  N  new fetch PC.
fault  output  1  sticky illegal-PC indication.
fault_pc  output  N  offending PC.

Behaviour:
- Reset (asynchronous, takes effect immediately with no clock edge):
  - state=IDLE, pc_out=RESET_PC
  - if_valid=0, if_inst=0, if_pc=0
  - fault=0, fault_pc=0
- States: IDLE, RUN, FAULT.
- IDLE:
  - No fetch; pc_out holds RESET_PC.
  - load_done=1 -> RUN at the next edge.
  - redirect_valid is ignored.
- RUN, slot free (if_valid=0 or if_ready=1), no redirect:
  - At the edge: if_inst<=inst_code, if_pc<=pc_out, if_valid<=1.
  - pc_out<=next, where next=(pc_out+4) mod MEM_BYTES. pc_out=MEM_BYTES-4 wraps to 0.
  - Latency: the instruction at address A is presented on if_inst one cycle after pc_out=A.
  - Throughput: one instruction per cycle while if_ready=1.
- RUN, slot full with if_ready=0, no redirect:
  - Hold pc_out, if_inst, if_pc, if_valid unchanged.
- RUN, redirect_valid=1 (highest priority, regardless of if_ready):
  - if_valid<=0, flushing any held instruction.
  - If redirect_pc[1:0]==0 and redirect_pc<=MEM_BYTES-4: pc_out<=redirect_pc. The first redirected instruction appears on if_inst two edges after the redirect cycle.
  - Otherwise: state<=FAULT, fault<=1, fault_pc<=redirect_pc, pc_out unchanged (always a legal address).
- FAULT:
  - No fetches; pc_out frozen; redirect_valid ignored.
  - if_valid stays 0.
  - fault and fault_pc hold until reset.
- Range check: compare redirect_pc at full N width. There is no truncation, so upper bits set means out of range.
- if_inst/if_pc are stable whenever if_valid=1 and if_ready=0.
- load_done deassertion after leaving IDLE has no effect.

Test Plan:
- Load gating: reset, load_done=0 for 5 cycles -> pc_out=0, if_valid=0 throughout. Pulse load_done -> RUN next edge; one edge later if_valid=1, if_pc=0, if_inst=mem word 0.
- Streaming and wrap (MEM_BYTES=32, if_ready=1) -> if_pc sequence 0,4,8,...,28,0,4 on consecutive cycles; if_inst matches the memory words.
- Backpressure: hold if_ready=0 for 3 cycles while if_pc=8 -> if_pc=8, if_inst and pc_out=12 unchanged. Release -> next edge if_pc=12.
- Redirect flush: redirect_pc=0x10 while if_valid=1, if_ready=0 -> next edge if_valid=0, pc_out=0x10. Following edge if_valid=1, if_pc=0x10.
- Fault, misaligned: redirect_pc=0x12 -> fault=1, fault_pc=0x12, if_valid=0, pc_out unchanged. A later legal redirect to 0x4 is ignored.
- Fault, out of range, and async reset: redirect_pc=0x20 -> fault=1, fault_pc=0x20. Assert reset between edges -> fault=0, pc_out=RESET_PC, if_valid=0 immediately.
